// File: rtl/iod_dly_pkg.sv
// Shared types and helpers for the IOD dynamic delay-line sequencer.
package iod_dly_pkg;

  localparam int IOD_TAP_W    = 8;
  localparam int RR_MAX_LANES = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LSETTLE,
    ST_CHECK,
    ST_MOVE,
    ST_SETTLE,
    ST_FINISH
  } state_t;

  // Index of the set bit in a one-hot grant; keeps ptr when nothing is granted.
  function automatic int rr_next(input logic [RR_MAX_LANES-1:0] onehot, input int ptr);
    int nxt;
    nxt = ptr;
    for (int i = 0; i < RR_MAX_LANES; i++)
      if (onehot[i]) nxt = i;
    return nxt;
  endfunction

endpackage

// File: rtl/iod_dly_line_seq_if.sv
// Training-side request/response bundle of the delay-line sequencer.
interface iod_dly_line_seq_if
  import iod_dly_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int TAP_W     = IOD_TAP_W
);
  logic [NUM_LANES-1:0]       REQ_VALID;
  logic [NUM_LANES-1:0]       REQ_READY;
  logic [NUM_LANES-1:0]       REQ_LOAD;
  logic [NUM_LANES*TAP_W-1:0] REQ_TARGET;
  logic [NUM_LANES-1:0]       DONE;
  logic [NUM_LANES-1:0]       ERR;

  modport master (output REQ_VALID, REQ_LOAD, REQ_TARGET, input REQ_READY, DONE, ERR);
  modport slave  (input REQ_VALID, REQ_LOAD, REQ_TARGET, output REQ_READY, DONE, ERR);
endinterface

// File: rtl/iod_dly_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts after the last accepted lane.
module iod_dly_rr_arb
  import iod_dly_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] req_vec,
  input  logic                 accept,
  output logic [NUM_LANES-1:0] grant,
  output logic [LANE_W-1:0]    grant_idx
);

  logic [LANE_W-1:0] ptr;

  always_comb begin
    int idx;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = (int'(ptr) + k) % NUM_LANES;
      if (grant == '0 && req_vec[idx]) grant[idx] = 1'b1;
    end
  end

  assign grant_idx = LANE_W'(rr_next(RR_MAX_LANES'(grant), int'(ptr)));

  always_ff @(posedge clk) begin
    if (rst)         ptr <= '0;
    else if (accept) ptr <= grant_idx;
  end

endmodule

// File: rtl/iod_dly_line_seq.sv
// Shared sequencer driving LOAD/DIRECTION/MOVE of several IOD dynamic delay lines.
module iod_dly_line_seq
  import iod_dly_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int TAP_W         = IOD_TAP_W,
  parameter int MAX_TAP       = 255,
  parameter int INIT_TAP      = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       FAB_CLK,
  input  logic                       SYNC_RST,
  iod_dly_line_seq_if.slave          lane_req,
  output logic [NUM_LANES*TAP_W-1:0] CUR_TAP,
  output logic                       BUSY,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] INIT_V   = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] ONE      = TAP_W'(1);

  state_t                           state;
  logic [LANE_W-1:0]                lane;
  logic [TAP_W-1:0]                 tgt;
  logic [CNT_W-1:0]                 cnt;
  logic [NUM_LANES-1:0][TAP_W-1:0]  tap_q;

  logic [NUM_LANES-1:0] grant;
  logic [LANE_W-1:0]    grant_idx;
  logic                 accept;
  logic                 sel_load;
  logic [TAP_W-1:0]     sel_tgt;

  iod_dly_rr_arb #(.NUM_LANES(NUM_LANES)) u_arb (
    .clk       (FAB_CLK),
    .rst       (SYNC_RST),
    .req_vec   (lane_req.REQ_VALID),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign lane_req.REQ_READY = (state == ST_IDLE && !SYNC_RST) ? grant : '0;
  assign accept   = |(lane_req.REQ_VALID & lane_req.REQ_READY);
  assign sel_load = lane_req.REQ_LOAD[grant_idx];
  assign sel_tgt  = lane_req.REQ_TARGET[grant_idx*TAP_W +: TAP_W];
  assign CUR_TAP  = tap_q;
  assign BUSY     = (state != ST_IDLE);

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state                <= ST_IDLE;
      lane                 <= '0;
      tgt                  <= '0;
      cnt                  <= '0;
      tap_q                <= {NUM_LANES{INIT_V}};
      DELAY_LINE_LOAD      <= '0;
      DELAY_LINE_MOVE      <= '0;
      DELAY_LINE_DIRECTION <= '0;
      lane_req.DONE        <= '0;
      lane_req.ERR         <= '0;
    end else begin
      // Strobes are single-cycle: set only on entry to their state.
      DELAY_LINE_LOAD <= '0;
      DELAY_LINE_MOVE <= '0;
      lane_req.DONE   <= '0;
      lane_req.ERR    <= '0;
      unique case (state)
        ST_IDLE: if (accept) begin
          lane <= grant_idx;
          tgt  <= sel_tgt;
          if (int'(sel_tgt) > MAX_TAP) begin
            lane_req.ERR[grant_idx] <= 1'b1;
            state                   <= ST_FINISH;
          end else if (sel_load) begin
            DELAY_LINE_LOAD[grant_idx] <= 1'b1;
            state                      <= ST_LOAD;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_LOAD: begin
          tap_q[lane] <= INIT_V;
          cnt         <= '0;
          state       <= ST_LSETTLE;
        end
        ST_LSETTLE: begin
          if (cnt == CNT_LAST) state <= ST_CHECK;
          else                 cnt   <= cnt + 1'b1;
        end
        ST_CHECK: begin
          if (tap_q[lane] == tgt) begin
            lane_req.DONE[lane] <= 1'b1;
            state               <= ST_FINISH;
          end else begin
            DELAY_LINE_DIRECTION[lane] <= (tgt > tap_q[lane]);
            DELAY_LINE_MOVE[lane]      <= 1'b1;
            state                      <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          tap_q[lane] <= DELAY_LINE_DIRECTION[lane] ? tap_q[lane] + ONE : tap_q[lane] - ONE;
          cnt         <= '0;
          state       <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Line refused the step: the tracked tap must not count it.
          if (DELAY_LINE_OUT_OF_RANGE[lane]) begin
            tap_q[lane]        <= DELAY_LINE_DIRECTION[lane] ? tap_q[lane] - ONE : tap_q[lane] + ONE;
            lane_req.ERR[lane] <= 1'b1;
            state              <= ST_FINISH;
          end else if (cnt == CNT_LAST) begin
            state <= ST_CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iod_dly_line_seq.sv
// Bench for iod_dly_line_seq: vector table, scoreboard of DONE/ERR timing, corner sequences.
module tb_iod_dly_line_seq;
  localparam int NL = 4;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iod_dly_line_seq_if #(.NUM_LANES(NL), .TAP_W(TW)) bif ();
  iod_dly_line_seq_if #(.NUM_LANES(NL), .TAP_W(TW)) sif ();

  logic [NL*TW-1:0] cur_tap, s_cur_tap;
  logic             busy, s_busy;
  logic [NL-1:0]    dl_load, dl_move, dl_dir, dl_oor;
  logic [NL-1:0]    s_load, s_move, s_dir, s_oor;

  iod_dly_line_seq #(.NUM_LANES(NL), .TAP_W(TW)) u_dut (
    .FAB_CLK(clk), .SYNC_RST(rst), .lane_req(bif), .CUR_TAP(cur_tap), .BUSY(busy),
    .DELAY_LINE_LOAD(dl_load), .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_DIRECTION(dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor)
  );

  iod_dly_line_seq #(.NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(63)) u_small (
    .FAB_CLK(clk), .SYNC_RST(rst), .lane_req(sif), .CUR_TAP(s_cur_tap), .BUSY(s_busy),
    .DELAY_LINE_LOAD(s_load), .DELAY_LINE_MOVE(s_move), .DELAY_LINE_DIRECTION(s_dir),
    .DELAY_LINE_OUT_OF_RANGE(s_oor)
  );

  typedef struct { int lane; bit ld; int tgt; int lat; int tap; int moves; bit dir; } vec_t;
  typedef struct { int lane; bit err; int t; int tap; } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  int   n_chk = 0, n_fail = 0;
  int   move_cnt = 0, load_cnt = 0, ovl_cnt = 0, dir_bad = 0;
  bit   exp_dir = 1'b1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: strobe exclusivity, direction at each MOVE, DONE/ERR against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(dl_move | dl_load) > 1 || (dl_move & dl_load) != '0) ovl_cnt++;
      move_cnt += $countones(dl_move);
      load_cnt += $countones(dl_load);
      for (int i = 0; i < NL; i++)
        if (dl_move[i] && dl_dir[i] != exp_dir) dir_bad++;
      if ((bif.DONE | bif.ERR) != '0) begin
        if (sb.size() == 0) chk("unexpected_done_err", longint'(bif.DONE | bif.ERR), 0);
        else begin
          mon_e = sb.pop_front();
          chk("resp_lane", longint'(bif.DONE | bif.ERR), longint'(1) << mon_e.lane);
          chk(mon_e.err ? "err_pulse" : "done_pulse",
              longint'(mon_e.err ? bif.ERR : bif.DONE), longint'(1) << mon_e.lane);
          chk("resp_cycle", cyc, mon_e.t);
          chk("cur_tap", longint'(cur_tap[mon_e.lane*TW +: TW]), mon_e.tap);
        end
      end
    end
  end

  task automatic issue(input int lane, input bit ld, input int tgt, input int lat,
                       input int tap, input bit err, output int t0);
    bit got;
    got = 1'b0;
    t0  = 0;
    @(negedge clk);
    bif.REQ_LOAD[lane]             = ld;
    bif.REQ_TARGET[lane*TW +: TW]  = TW'(tgt);
    bif.REQ_VALID[lane]            = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (bif.REQ_READY[lane]) begin
        got = 1'b1;
        t0  = cyc;
        sb.push_back('{lane, err, t0 + lat, tap});
      end else @(negedge clk);
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bif.REQ_VALID[lane] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("completion_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bif.REQ_VALID = '0; bif.REQ_LOAD = '0; bif.REQ_TARGET = '0;
    sif.REQ_VALID = '0; sif.REQ_LOAD = '0; sif.REQ_TARGET = '0;
    dl_oor = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int   t0, mc, g, k;
    int   order[4];
    int   acc_cnt[NL];
    int   err_seen, err_t, done_seen, ml;

    vt[0] = '{0, 1'b0, 4,   14,   4,   3,   1'b1};
    vt[1] = '{1, 1'b0, 3,   10,   3,   2,   1'b1};
    vt[2] = '{1, 1'b1, 0,   9,    0,   1,   1'b0};
    vt[3] = '{3, 1'b0, 255, 1018, 255, 254, 1'b1};
    vt[4] = '{3, 1'b0, 255, 2,    255, 0,   1'b1};
    vt[5] = '{0, 1'b1, 1,   5,    1,   0,   1'b1};
    vt[6] = '{2, 1'b0, 0,   6,    0,   1,   1'b0};
    order = '{1, 2, 3, 0};
    s_oor = '0;

    do_reset();
    #1;
    chk("rst_busy",    busy, 0);
    chk("rst_ready",   bif.REQ_READY, 0);
    chk("rst_done_err", longint'(bif.DONE | bif.ERR), 0);
    chk("rst_strobes", longint'(dl_move | dl_load | dl_dir), 0);
    chk("rst_cur_tap", cur_tap, 32'h01010101);

    // Table-driven single requests
    foreach (vt[i]) begin
      exp_dir  = vt[i].dir;
      move_cnt = 0;
      load_cnt = 0;
      issue(vt[i].lane, vt[i].ld, vt[i].tgt, vt[i].lat, vt[i].tap, 1'b0, t0);
      drain(1100);
      chk("move_count", move_cnt, vt[i].moves);
      chk("load_count", load_cnt, vt[i].ld);
    end

    // All lanes request together after reset: pointer at 0, so 1,2,3,0
    do_reset();
    exp_dir = 1'b1;
    acc_cnt = '{0, 0, 0, 0};
    @(negedge clk);
    for (int i = 0; i < NL; i++) bif.REQ_TARGET[i*TW +: TW] = 8'd2;
    bif.REQ_VALID = '1;
    k = 0;
    for (int c = 0; c < 100 && k < 4; c++) begin
      #1;
      if (bif.REQ_READY != '0) begin
        chk("ready_onehot", $countones(bif.REQ_READY), 1);
        g = 0;
        for (int i = 0; i < NL; i++) if (bif.REQ_READY[i]) g = i;
        chk("grant_order", g, order[k]);
        acc_cnt[g]++;
        sb.push_back('{g, 1'b0, cyc + 6, 2});
        k++;
        @(posedge clk);
        #1 bif.REQ_VALID[g] = 1'b0;
      end
      @(negedge clk);
    end
    chk("all_granted", k, 4);
    for (int i = 0; i < NL; i++) chk("ready_once", acc_cnt[i], 1);
    drain(100);

    // Out-of-range in the 2nd settle cycle after the 5th step of lane2
    do_reset();
    exp_dir  = 1'b1;
    move_cnt = 0;
    issue(2, 1'b0, 10, 21, 5, 1'b1, t0);
    mc = 0;
    for (int c = 0; c < 100 && mc < 5; c++) begin
      @(negedge clk);
      if (dl_move[2]) mc++;
    end
    chk("oor_reached_5th_move", mc, 5);
    @(negedge clk);
    @(negedge clk);
    dl_oor[2] = 1'b1;
    @(posedge clk);
    #1 dl_oor[2] = 1'b0;
    drain(50);
    chk("oor_move_count", move_cnt, 5);

    // Reset during SETTLE of a 10-tap move aborts silently
    do_reset();
    issue(1, 1'b0, 11, 42, 11, 1'b0, t0);
    mc = 0;
    for (int c = 0; c < 100 && mc < 3; c++) begin
      @(negedge clk);
      if (dl_move[1]) mc++;
    end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",    busy, 0);
    chk("mid_rst_strobes", longint'(dl_move | dl_load | dl_dir), 0);
    chk("mid_rst_resp",    longint'(bif.DONE | bif.ERR), 0);
    chk("mid_rst_cur_tap", cur_tap, 32'h01010101);
    repeat (40) @(negedge clk);
    load_cnt = 0;
    issue(1, 1'b1, 2, 9, 2, 1'b0, t0);
    drain(50);
    chk("post_rst_load", load_cnt, 1);

    // Target above MAX_TAP=63 is rejected without any pulse
    err_seen = 0; err_t = 0; done_seen = 0; ml = 0;
    @(negedge clk);
    sif.REQ_TARGET[7:0] = 8'd64;
    sif.REQ_VALID[0]    = 1'b1;
    #1;
    chk("small_ready", sif.REQ_READY, 1);
    t0 = cyc;
    @(posedge clk);
    #1 sif.REQ_VALID[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (sif.ERR[0]) begin err_seen++; err_t = cyc; end
      if (sif.DONE != '0) done_seen++;
      ml += $countones(s_move | s_load);
    end
    chk("range_err_count", err_seen, 1);
    chk("range_err_cycle", err_t, t0 + 1);
    chk("range_no_done",   done_seen, 0);
    chk("range_no_pulses", ml, 0);

    chk("no_strobe_overlap", ovl_cnt, 0);
    chk("direction_at_move", dir_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iod_dly_line_seq.md
Name: iod_dly_line_seq

Overview:
- Shared sequencer for the dynamic delay lines of a group of DDR3 IOD lanes (DQ/DQS/ODT/CA lanes, DELAY_LINE_MODE dynamic).
- Accepts absolute-tap requests from several lanes and services them one at a time, in round-robin order.
- For each request it issues LOAD/DIRECTION/MOVE pulses and tracks each lane's current tap.
- Catches DELAY_LINE_OUT_OF_RANGE and reports completion or error per lane. Sits between the training FSMs and the IOD instances.

Parameters:
- NUM_LANES, 4, number of IOD lanes served.
- TAP_W, 8, tap counter width; matches the IOD 8-bit delay value.
- MAX_TAP, 255, highest legal tap; a target above this is rejected.
- INIT_TAP, 1, tap value after reset and after LOAD; matches the IOD static TX/RX_DELAY_VAL.
- SETTLE_CYCLES, 2, wait cycles after each MOVE pulse (at least 1).

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on its rising edge.
- SYNC_RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  NUM_LANES  per-lane request valid.
- REQ_READY  out  NUM_LANES  per-lane request accept; one-hot or zero.
- REQ_LOAD  in  NUM_LANES  when 1, reload the line to INIT_TAP before stepping.
- REQ_TARGET  in  NUM_LANES*TAP_W  per-lane target tap; lane i is in bits [i*TAP_W +: TAP_W].
- DONE  out  NUM_LANES  1-cycle pulse: target tap reached.
- ERR  out  NUM_LANES  1-cycle pulse: target rejected or out-of-range hit.
- CUR_TAP  out  NUM_LANES*TAP_W  tracked tap per lane.
- BUSY  out  1  high whenever the FSM is not IDLE.
- DELAY_LINE_LOAD  out  NUM_LANES  to IOD DELAY_LINE_LOAD.
- DELAY_LINE_MOVE  out  NUM_LANES  to IOD DELAY_LINE_MOVE.
- DELAY_LINE_DIRECTION  out  NUM_LANES  to IOD DELAY_LINE_DIRECTION; 1 = increment.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  from IOD.

Behaviour:
- Interface: clock FAB_CLK; one clock; reset SYNC_RST is synchronous and active-high.
- Reset values:
  - DONE, ERR, REQ_READY, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, BUSY = 0.
  - CUR_TAP[i] = INIT_TAP.
  - FSM = IDLE; round-robin pointer = lane 0.
- Reset mid-operation aborts the request on the next edge. MOVE/LOAD drop and no DONE/ERR is issued.
- The training logic must re-LOAD after reset, because the real line position is unknown.
- FSM states: IDLE, LOAD, LSETTLE, CHECK, MOVE, SETTLE, FINISH.
- IDLE:
  - Round-robin arbiter over REQ_VALID. Search starts at the lane after the last granted lane.
  - REQ_READY[g] = IDLE & grant[g]. It is combinational from REQ_VALID and the pointer.
  - Handshake: a request transfers on REQ_VALID & REQ_READY. On transfer, latch lane g, target and load flag; update the pointer to g.
- Target check on accept:
  - If REQ_TARGET > MAX_TAP, go to FINISH with ERR and issue no pulses.
  - Otherwise, if load=1 go to LOAD, else go to CHECK.
- LOAD: DELAY_LINE_LOAD[g]=1 for one cycle. CUR_TAP[g] := INIT_TAP. Then LSETTLE for SETTLE_CYCLES cycles, then CHECK.
- CHECK:
  - If CUR_TAP[g]==target, go to FINISH with DONE.
  - Otherwise DELAY_LINE_DIRECTION[g] := (target > CUR_TAP[g]), registered, then MOVE.
- MOVE: DELAY_LINE_MOVE[g]=1 for exactly one cycle. CUR_TAP[g] ±= 1. Then SETTLE.
- DIRECTION stays stable from the cycle after CHECK through the end of SETTLE.
- DIRECTION bits of non-granted lanes keep their last value.
- SETTLE:
  - Counter runs 0..SETTLE_CYCLES-1, then back to CHECK.
  - DELAY_LINE_OUT_OF_RANGE[g] is sampled every SETTLE cycle. If high: undo the last step (CUR_TAP[g] reverts) and go to FINISH with ERR.
- FINISH: DONE[g] or ERR[g] pulses for one cycle, never both. Next state IDLE.
- Latency:
  - Accept cycle = t0. Without load, DONE occurs at t0 + N*(SETTLE_CYCLES+2) + 2, where N = |target - start tap|.
  - load=1 adds SETTLE_CYCLES+1.
  - Next accept is possible the cycle after FINISH.
- Only one lane's MOVE/LOAD is ever high in a given cycle. Requests on other lanes wait; their REQ_VALID must stay high until READY.
- CUR_TAP has no wrap-around: stepping stays within 0..MAX_TAP because the target is bounded.

Decomposition:
- Package iod_dly_pkg holds:
  - FSM state enum.
  - TAP_W default.
  - Function rr_next(onehot, ptr).
- Sub-module iod_dly_rr_arb: parameterised NUM_LANES round-robin arbiter with one-hot grant and pointer update on accept.
- Remaining FSM, counters and per-lane registers stay in the top module.

Test Plan:
- Reset, then lane0 request target=4, load=0, SETTLE=2. Required:
  - Three MOVE pulses with DIRECTION=1.
  - DONE[0] at t0+14.
  - CUR_TAP[0]=4.
- Lane1 load=1, target=0, after lane1 was at 3. Required:
  - LOAD pulse, CUR_TAP=1.
  - One MOVE with DIRECTION=0.
  - DONE at t0+3+4+2=t0+9.
- Lanes 0..3 all valid together, pointer at 0. Required:
  - Grants in order 1,2,3,0, each REQ_READY a single cycle.
  - No overlapping MOVE.
- Lane2 target=10 with OUT_OF_RANGE forced high in the 2nd SETTLE cycle after the 5th MOVE. Required:
  - ERR[2] pulse and no DONE.
  - CUR_TAP[2]=INIT_TAP+4.
- Parameter MAX_TAP=63, target=64. Required: ERR at t0+1, no MOVE/LOAD pulses.
- SYNC_RST asserted during SETTLE of a 10-tap move. Required:
  - All outputs 0 and CUR_TAP=INIT_TAP on the next edge.
  - No DONE/ERR.
  - A new request is accepted after reset deasserts.
